// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the AXI write-path arbiter.
// The optional watchdog is enabled with the AXI_WR_TIMEOUT_EN macro.
package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        WA_IDLE,
        WA_ADDR,
        WA_DATA,
        WA_RESP
    } wa_state_t;

    localparam logic [1:0] MSEL_NONE = 2'd0;
    localparam logic [1:0] MSEL_M1   = 2'd1;
    localparam logic [1:0] MSEL_M2   = 2'd2;

    // Owner index for the W/B muxes from a one-hot grant.
    function automatic logic [1:0] gnt_to_msel(input logic [1:0] gnt);
        logic [1:0] msel;
        msel = MSEL_NONE;
        if (gnt[0]) begin
            msel = MSEL_M1;
        end else if (gnt[1]) begin
            msel = MSEL_M2;
        end
        return msel;
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_arb2.sv
// Two-input combinational round-robin pick.
// ptr_i = 0 prefers req_i[0] (M1), ptr_i = 1 prefers req_i[1] (M2).
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // A lone requester wins outright; a tie goes to the preferred side.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Write-path arbiter/sequencer: grants M1 or M2 ownership from AW through
// W-last to the B handshake and drives the W/B mux select and lock.
// Optional watchdog on DATA/RESP is built when AXI_WR_TIMEOUT_EN is defined.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned NUM_REQ        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] awvalid_req_i,
    input  logic               aw_hs_i,
    input  logic               w_last_hs_i,
    input  logic               b_hs_i,
    output logic [1:0]         grant_o,
    output logic [1:0]         master_sel_o,
    output logic               lock_o,
    output logic               timeout_o
);

    wa_state_t  state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] msel_q, msel_d;
    logic       wdone_q, wdone_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [1:0] pick_gnt;
    logic       release_txn;
    logic       expire;

    rr_arb2 u_rr_arb2 (
        .req_i (awvalid_req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt)
    );

    // Next-state and registered-output logic for the write ownership FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        msel_d      = msel_q;
        wdone_d     = wdone_q;
        rr_ptr_d    = rr_ptr_q;
        release_txn = 1'b0;
        case (state_q)
            WA_IDLE: begin
                if (|awvalid_req_i) begin
                    state_d = WA_ADDR;
                    grant_d = pick_gnt;
                    msel_d  = gnt_to_msel(pick_gnt);
                end
            end
            WA_ADDR: begin
                if (aw_hs_i) begin
                    state_d = (wdone_q || w_last_hs_i) ? WA_RESP : WA_DATA;
                end else if (w_last_hs_i) begin
                    // Write data finished ahead of the address.
                    wdone_d = 1'b1;
                end
            end
            WA_DATA: begin
                if (w_last_hs_i) begin
                    state_d = WA_RESP;
                end
            end
            WA_RESP: begin
                if (b_hs_i) begin
                    release_txn = 1'b1;
                end
            end
            default: begin
                state_d = WA_IDLE;
            end
        endcase
        // Completion and watchdog expiry both drop ownership and rotate priority.
        if (release_txn || expire) begin
            state_d  = WA_IDLE;
            grant_d  = 2'b00;
            msel_d   = MSEL_NONE;
            wdone_d  = 1'b0;
            rr_ptr_d = grant_q[0];
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WA_IDLE;
            grant_q  <= 2'b00;
            msel_q   <= MSEL_NONE;
            wdone_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            msel_q   <= msel_d;
            wdone_q  <= wdone_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;
    logic             in_wait;
    logic             progress;

    assign in_wait  = (state_q == WA_DATA) || (state_q == WA_RESP);
    assign progress = ((state_q == WA_DATA) && w_last_hs_i) ||
                      ((state_q == WA_RESP) && b_hs_i);
    // Expire on the cycle the count would reach the limit, unless the phase completes.
    assign expire   = in_wait && !progress &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog count: restart on entering DATA/RESP, saturating increment while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (((state_d == WA_DATA) || (state_d == WA_RESP)) && (state_d != state_q)) begin
            cnt_d = '0;
        end else if (in_wait && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog counter and one-cycle expiry pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= expire;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign expire             = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    assign grant_o      = grant_q;
    assign master_sel_o = msel_q;
    assign lock_o       = (state_q != WA_IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed vector table, hand-written
// reset/timeout sequences, and randomized traffic against a transaction model.
module tb_axi_wr_arbiter;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic       aw  = 1'b0;
    logic       wl  = 1'b0;
    logic       b   = 1'b0;
    logic [1:0] grant_o;
    logic [1:0] master_sel_o;
    logic       lock_o;
    logic       timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    axi_wr_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .NUM_REQ        (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .awvalid_req_i (req),
        .aw_hs_i       (aw),
        .w_last_hs_i   (wl),
        .b_hs_i        (b),
        .grant_o       (grant_o),
        .master_sel_o  (master_sel_o),
        .lock_o        (lock_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input int idx, input logic [1:0] eg,
                         input logic [1:0] ems, input logic elk, input logic etm);
        n_cmp++;
        if ({grant_o, master_sel_o, lock_o, timeout_o} !== {eg, ems, elk, etm}) begin
            n_err++;
            $display("FAIL %s[%0d]: got grant=%b sel=%0d lock=%b tmo=%b, want grant=%b sel=%0d lock=%b tmo=%b",
                     nm, idx, grant_o, master_sel_o, lock_o, timeout_o, eg, ems, elk, etm);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic a, input logic w, input logic bb);
        @(negedge clk);
        req = r; aw = a; wl = w; b = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = 2'b00; aw = 1'b0; wl = 1'b0; b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    // Owner 0 = none, 1 = M1, 2 = M2. A transaction completes once the address
    // phase, the data phase and the response have each been observed.
    int   m_owner;
    int   m_last;
    bit   m_aw;
    bit   m_w;
    int   m_cnt;
    bit   m_tmo;

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_aw = 0; m_w = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_finish();
        m_last = m_owner; m_owner = 0; m_aw = 0; m_w = 0;
    endtask

    task automatic model_wait_tick();
`ifdef AXI_WR_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == int'(TMO)) begin
            m_tmo = 1;
            model_finish();
        end
`endif
    endtask

    task automatic model_step(input logic [1:0] r, input logic a, input logic w, input logic bb);
        m_tmo = 0;
        if (m_owner == 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) m_owner = (m_last == 1) ? 2 : 1;
                else            m_owner = r[0] ? 1 : 2;
                m_aw = 0; m_w = 0;
            end
        end else if (!m_aw) begin
            if (a) begin
                m_aw = 1; m_cnt = 0;
            end
            if (w) m_w = 1;
        end else if (!m_w) begin
            if (w) begin
                m_w = 1; m_cnt = 0;
            end else begin
                model_wait_tick();
            end
        end else begin
            if (bb) model_finish();
            else    model_wait_tick();
        end
    endtask

    function automatic logic [1:0] own_gnt(input int o);
        return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] r;
        logic       a;
        logic       w;
        logic       bb;
        logic [1:0] eg;
        logic [1:0] ems;
        logic       elk;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic a, input logic w,
                                input logic bb, input logic [1:0] eg,
                                input logic [1:0] ems, input logic elk);
        vec_t v;
        v.r = r; v.a = a; v.w = w; v.bb = bb; v.eg = eg; v.ems = ems; v.elk = elk;
        return v;
    endfunction

    vec_t tbl[28];

    initial begin
        int k;
        int hit;

        // Tie from reset, single-beat write, request held across b_hs, rotation.
        tbl[0]  = mk(2'b11, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[1]  = mk(2'b11, 1, 1, 0, 2'b01, 2'd1, 1);
        tbl[2]  = mk(2'b11, 0, 0, 1, 2'b00, 2'd0, 0);
        tbl[3]  = mk(2'b10, 0, 0, 0, 2'b10, 2'd2, 1);
        tbl[4]  = mk(2'b10, 1, 0, 0, 2'b10, 2'd2, 1);
        tbl[5]  = mk(2'b00, 0, 0, 1, 2'b10, 2'd2, 1);
        tbl[6]  = mk(2'b00, 0, 1, 0, 2'b10, 2'd2, 1);
        tbl[7]  = mk(2'b00, 0, 0, 1, 2'b00, 2'd0, 0);
        tbl[8]  = mk(2'b11, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[9]  = mk(2'b01, 1, 0, 0, 2'b01, 2'd1, 1);
        tbl[10] = mk(2'b00, 0, 1, 0, 2'b01, 2'd1, 1);
        tbl[11] = mk(2'b00, 0, 0, 1, 2'b00, 2'd0, 0);
        // W-last two cycles ahead of AW: DATA skipped, b_hs accepted right after AW.
        tbl[12] = mk(2'b01, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[13] = mk(2'b01, 0, 1, 0, 2'b01, 2'd1, 1);
        tbl[14] = mk(2'b01, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[15] = mk(2'b01, 1, 0, 0, 2'b01, 2'd1, 1);
        tbl[16] = mk(2'b00, 0, 0, 1, 2'b00, 2'd0, 0);
        // Spurious handshakes in IDLE, W-last ignored in RESP, req dropped in ADDR.
        tbl[17] = mk(2'b00, 1, 1, 1, 2'b00, 2'd0, 0);
        tbl[18] = mk(2'b10, 0, 0, 0, 2'b10, 2'd2, 1);
        tbl[19] = mk(2'b00, 1, 1, 0, 2'b10, 2'd2, 1);
        tbl[20] = mk(2'b00, 0, 1, 0, 2'b10, 2'd2, 1);
        tbl[21] = mk(2'b01, 0, 0, 1, 2'b00, 2'd0, 0);
        // Four-beat write for M1 after M2 owned last.
        tbl[22] = mk(2'b11, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[23] = mk(2'b00, 1, 0, 0, 2'b01, 2'd1, 1);
        tbl[24] = mk(2'b00, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[25] = mk(2'b00, 0, 0, 0, 2'b01, 2'd1, 1);
        tbl[26] = mk(2'b00, 0, 1, 0, 2'b01, 2'd1, 1);
        tbl[27] = mk(2'b00, 0, 0, 1, 2'b00, 2'd0, 0);

        // Reset state while held in reset.
        #1;
        check("reset_hold", 0, 2'b00, 2'd0, 1'b0, 1'b0);
        do_reset();
        #1;
        check("reset_release", 0, 2'b00, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].r, tbl[i].a, tbl[i].w, tbl[i].bb);
            check("vec", i, tbl[i].eg, tbl[i].ems, tbl[i].elk, 1'b0);
        end

        // Reset asserted in the middle of a DATA phase.
        do_reset();
        drive(2'b01, 0, 0, 0);
        check("mid_rst_grant", 0, 2'b01, 2'd1, 1'b1, 1'b0);
        drive(2'b00, 1, 0, 0);
        check("mid_rst_data", 0, 2'b01, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        aw = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_async", 0, 2'b00, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_held", 0, 2'b00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b10, 0, 0, 0);
        check("post_rst_m2", 0, 2'b10, 2'd2, 1'b1, 1'b0);
        drive(2'b00, 1, 1, 0);
        check("post_rst_resp", 0, 2'b10, 2'd2, 1'b1, 1'b0);
        drive(2'b00, 0, 0, 1);
        check("post_rst_done", 0, 2'b00, 2'd0, 1'b0, 1'b0);
        drive(2'b11, 0, 0, 0);
        check("post_rst_rotate", 0, 2'b01, 2'd1, 1'b1, 1'b0);
        drive(2'b00, 1, 1, 0);
        drive(2'b00, 0, 0, 1);
        check("post_rst_idle", 0, 2'b00, 2'd0, 1'b0, 1'b0);

`ifdef AXI_WR_TIMEOUT_EN
        // Stall in RESP until the watchdog fires.
        do_reset();
        drive(2'b01, 0, 0, 0);
        drive(2'b00, 1, 1, 0);
        check("tmo_resp_entry", 0, 2'b01, 2'd1, 1'b1, 1'b0);
        hit = 0;
        for (k = 1; k <= 40; k++) begin
            drive(2'b00, 0, 0, 0);
            if (timeout_o === 1'b1) begin
                hit = k;
                break;
            end
        end
        n_cmp++;
        if (hit != int'(TMO)) begin
            n_err++;
            $display("FAIL tmo_latency: got %0d cycles, want %0d", hit, TMO);
        end
        check("tmo_outputs", 0, 2'b00, 2'd0, 1'b0, 1'b1);
        drive(2'b00, 0, 0, 0);
        check("tmo_pulse_end", 0, 2'b00, 2'd0, 1'b0, 1'b0);
        drive(2'b11, 0, 0, 0);
        check("tmo_rotate", 0, 2'b10, 2'd2, 1'b1, 1'b0);
`endif

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic       rl;
            logic [1:0] r;
            logic       a, w, bb;
            rl = ($urandom_range(0, 249) == 0);
            r  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 2) == 0);
            w  = ($urandom_range(0, 2) == 0);
            bb = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            rst = !rl; req = r; aw = a; wl = w; b = bb;
            @(posedge clk);
            if (rl) model_reset();
            else    model_step(r, a, w, bb);
            #1;
            check("rand", c, own_gnt(m_owner), 2'(m_owner), (m_owner != 0), m_tmo);
        end

        @(negedge clk);
        rst = 1'b1; req = 2'b00; aw = 1'b0; wl = 1'b0; b = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
